uart_tx_streamer: RTL and testbench

- Transmit-side counterpart of the receive path: FPGA logic pushes bytes through a valid/ready interface into an internal FIFO.
- An internal serializer sends each byte as a standard 8N1 UART frame on `tx` toward the ESP32.
- The block contains its own 16x oversampling tick counter, so it stands alone next to the receive path.

---
 rtl/uart_tx_streamer_if.sv | 18 +
 rtl/uart_tx_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_uart_tx_streamer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_streamer_if.sv
// +----------------------------------------------------------------------------+
// | uart_tx_streamer_if : valid/ready byte-write channel into the TX streamer  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_tx_streamer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    modport master (output wr_data, output wr_valid, input  wr_ready);
    modport slave  (input  wr_data, input  wr_valid, output wr_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_streamer.sv
// +----------------------------------------------------------------------------+
// | uart_tx_streamer : byte FIFO feeding an 8N1 UART serializer (16x ticks).   |
// | Optional even parity bit with macro UART_TX_PARITY_EN.  Rev 1.0            |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_streamer #(
    parameter int DATA_BITS     = 8,
    parameter int STOP_BIT_TICK = 16,
    parameter int BR_LIMIT      = 326,
    parameter int BR_BITS       = 9,
    parameter int FIFO_EXP      = 4
) (
    input  wire logic          clk_50MHz,
    input  wire logic          reset,
    uart_tx_streamer_if.slave  wr,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_done_tick,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [FIFO_EXP:0]  fifo_count
);

    localparam int DEPTH   = 1 << FIFO_EXP;
    localparam int TICK_MX = (STOP_BIT_TICK > 16) ? STOP_BIT_TICK : 16;
    localparam int TICK_W  = $clog2(TICK_MX);
    localparam int BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_EXP-1:0]  wptr;
    logic [FIFO_EXP-1:0]  rptr;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign fifo_full   = (fifo_count == (FIFO_EXP+1)'(DEPTH));
    assign fifo_empty  = (fifo_count == '0);
    assign wr.wr_ready = !fifo_full;
    assign push        = wr.wr_valid && !fifo_full;
    assign head        = mem[rptr];

    always_ff @(posedge clk_50MHz) begin
        if (push) begin
            mem[wptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wptr <= wptr + FIFO_EXP'(1);
            if (pop)  rptr <= rptr + FIFO_EXP'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (FIFO_EXP+1)'(1);
                2'b01:   fifo_count <= fifo_count - (FIFO_EXP+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- Serializer ----------------
    state_t               state;
    logic [BR_BITS-1:0]   br_cnt;
    logic [TICK_W-1:0]    s_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 tick;
    logic                 bit_end;
    logic                 stop_end;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign tick      = (br_cnt == BR_BITS'(BR_LIMIT - 1));
    assign bit_end   = tick && (s_cnt == TICK_W'(15));
    assign stop_end  = tick && (s_cnt == TICK_W'(STOP_BIT_TICK - 1));
    assign shift_nxt = shift >> 1;

    // A byte is taken from the FIFO only when idle or at the very end of a stop bit,
    // which is what gives back-to-back frames with no idle gap.
    assign pop          = !fifo_empty && ((state == IDLE) || ((state == STOP) && stop_end));
    assign tx_done_tick = (state == STOP) && stop_end;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            br_cnt  <= '0;
            s_cnt   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if ((state == IDLE) && pop) begin
                br_cnt <= '0;
            end else if (tick) begin
                br_cnt <= '0;
            end else begin
                br_cnt <= br_cnt + BR_BITS'(1);
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= head;
`ifdef UART_TX_PARITY_EN
                        par     <= ^head;
`endif
                        s_cnt   <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        s_cnt   <= '0;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else if (tick) begin
                        s_cnt <= s_cnt + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shift   <= shift_nxt;
                            tx      <= shift_nxt[0];
                        end
                    end else if (tick) begin
                        s_cnt <= s_cnt + TICK_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        s_cnt <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else if (tick) begin
                        s_cnt <= s_cnt + TICK_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (stop_end) begin
                        s_cnt <= '0;
                        if (pop) begin
                            shift <= head;
`ifdef UART_TX_PARITY_EN
                            par   <= ^head;
`endif
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (tick) begin
                        s_cnt <= s_cnt + TICK_W'(1);
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_streamer.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_streamer : random + directed bench with a frame-position model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_streamer;

    localparam int DB     = 8;
    localparam int STB    = 16;
    localparam int BRL    = 4;
    localparam int BRB    = 3;
    localparam int FE     = 4;
    localparam int DEPTH  = 1 << FE;
    localparam int BITCLK = 16 * BRL;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FRAME  = (16 * (1 + DB + PB) + STB) * BRL;
    localparam int LOGN   = 2 * FRAME + 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #10 clk = ~clk;

    uart_tx_streamer_if #(.DATA_BITS(DB)) wr ();

    logic          tx;
    logic          tx_busy;
    logic          tx_done_tick;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FE:0]   fifo_count;

    uart_tx_streamer #(
        .DATA_BITS(DB), .STOP_BIT_TICK(STB), .BR_LIMIT(BRL),
        .BR_BITS(BRB), .FIFO_EXP(FE)
    ) dut (
        .clk_50MHz   (clk),
        .reset       (reset),
        .wr          (wr),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done_tick(tx_done_tick),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Model: a queue of accepted bytes plus the clock position inside the frame in flight.
    logic [DB-1:0] mq [$];
    bit            m_act = 1'b0;
    int            m_pos = 0;
    logic [DB-1:0] m_cur = '0;
    bit            m_push;
    bit            m_pop;
    int            m_sz;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_act = 1'b0;
            m_pos = 0;
        end else begin
            m_sz   = mq.size();
            m_push = wr.wr_valid && (m_sz < DEPTH);
            m_pop  = (m_sz > 0) && (!m_act || (m_pos == FRAME - 1));
            if (m_act && (m_pos != FRAME - 1)) begin
                m_pos++;
            end else if (m_pop) begin
                m_act = 1'b1;
                m_pos = 0;
                m_cur = mq.pop_front();
            end else begin
                m_act = 1'b0;
            end
            if (m_push) mq.push_back(wr.wr_data);
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (!m_act) return 1'b1;
        slot = m_pos / BITCLK;
        if (slot == 0) return 1'b0;
        if (slot <= DB) return m_cur[slot-1];
        if ((PB == 1) && (slot == DB + 1)) return ^m_cur;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("tx",         tx,           exp_tx());
            chk("tx_busy",    tx_busy,      m_act);
            chk("tx_done",    tx_done_tick, m_act && (m_pos == FRAME - 1));
            chk("fifo_count", fifo_count,   mq.size());
            chk("fifo_full",  fifo_full,    mq.size() == DEPTH);
            chk("fifo_empty", fifo_empty,   mq.size() == 0);
            chk("wr_ready",   wr.wr_ready,  mq.size() != DEPTH);
            if (tx_done_tick) n_done++;
        end
    end

    logic tx_log   [LOGN];
    logic done_log [LOGN];
    logic busy_log [LOGN];

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tx_log[i]   = tx;
            done_log[i] = tx_done_tick;
            busy_log[i] = tx_busy;
            @(negedge clk);
        end
    endtask

    task automatic write_burst(input logic [DB-1:0] b [$]);
        foreach (b[i]) begin
            wr.wr_valid = 1'b1;
            wr.wr_data  = b[i];
            @(negedge clk);
        end
        wr.wr_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (!(fifo_empty && !tx_busy) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        chk("drain_in_time", k < budget, 1'b1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [10:0]   pat;
    logic [DB-1:0] bq [$];
    logic [DB-1:0] e1, e2;
    int            cnt_done;
    int            idx_done;
    int            cnt_idle;
    int            d0;
    int            k;

    initial begin
        wr.wr_valid = 1'b0;
        wr.wr_data  = '0;
        wait_cycles(3);
        #2 reset = 1'b1;
        @(negedge clk);

        chk("rst_tx",    tx,          1'b1);
        chk("rst_busy",  tx_busy,     1'b0);
        chk("rst_empty", fifo_empty,  1'b1);
        chk("rst_count", fifo_count,  0);
        chk("rst_ready", wr.wr_ready, 1'b1);
        wait_cycles(5);

        // Single 0x55 frame: line goes low on the second sample after the write.
`ifdef UART_TX_PARITY_EN
        pat = 11'b1_0_01010101_0;
`else
        pat = 11'b0_1_01010101_0;
`endif
        wr.wr_valid = 1'b1; wr.wr_data = 8'h55;
        @(negedge clk);
        wr.wr_valid = 1'b0;
        chk("lat_still_high", tx, 1'b1);
        @(negedge clk);
        chk("lat_low", tx, 1'b0);
        capture(FRAME);
        for (int b = 0; b < 10 + PB; b++) begin
            chk("p55_first", tx_log[b*BITCLK],          pat[b]);
            chk("p55_mid",   tx_log[b*BITCLK + 32],     pat[b]);
            chk("p55_last",  tx_log[b*BITCLK + 63],     pat[b]);
        end
        cnt_done = 0; idx_done = -1;
        for (int i = 0; i < FRAME; i++) if (done_log[i]) begin cnt_done++; idx_done = i; end
        chk("p55_done_cnt", cnt_done, 1);
        chk("p55_done_idx", idx_done, (PB == 1) ? 703 : 639);
        chk("p55_after_tx",   tx,      1'b1);
        chk("p55_after_busy", tx_busy, 1'b0);
        wait_cycles(10);

        // Back-to-back 0xA5, 0x3C.
        e1 = 8'hA5; e2 = 8'h3C;
        bq = '{8'hA5, 8'h3C};
        write_burst(bq);
        capture(2 * FRAME);
        cnt_done = 0; cnt_idle = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (done_log[i]) cnt_done++;
            if (!busy_log[i]) cnt_idle++;
        end
        chk("b2b_done_cnt", cnt_done, 2);
        chk("b2b_no_gap",   cnt_idle, 0);
        chk("b2b_start2",   tx_log[FRAME + 32], 1'b0);
        for (int b = 0; b < 8; b++) begin
            chk("b2b_a5", tx_log[(b + 1) * BITCLK + 32],         e1[b]);
            chk("b2b_3c", tx_log[FRAME + (b + 1) * BITCLK + 32], e2[b]);
        end
        chk("b2b_a5_lsb", tx_log[BITCLK + 32], 1'b1);
        chk("b2b_3c_lsb", tx_log[FRAME + BITCLK + 32], 1'b0);
        wait_cycles(10);

        // Overflow: 17 writes behind a busy frame.
        bq = '{8'hEE};
        write_burst(bq);
        wait_cycles(2);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                chk("ovf_ready", wr.wr_ready, 1'b0);
                chk("ovf_full",  fifo_full,   1'b1);
                chk("ovf_count", fifo_count,  16);
            end
            wr.wr_valid = 1'b1;
            wr.wr_data  = 8'(i);
            @(negedge clk);
        end
        wr.wr_valid = 1'b0;
        d0 = n_done;
        drain(20 * FRAME);
        chk("ovf_frames", n_done - d0, 17);
        wait_cycles(10);

        // Async reset mid-DATA with bytes queued.
        bq = '{8'hFF, 8'h11, 8'h22, 8'h33};
        write_burst(bq);
        wait_cycles(3 * BITCLK);
        #3 reset = 1'b0;
        #1;
        chk("arst_tx",    tx,         1'b1);
        chk("arst_busy",  tx_busy,    1'b0);
        chk("arst_empty", fifo_empty, 1'b1);
        chk("arst_count", fifo_count, 0);
        wait_cycles(3);
        #2 reset = 1'b1;
        d0 = n_done; cnt_idle = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx_busy || !tx) cnt_idle++;
        end
        chk("arst_quiet", cnt_idle, 0);
        chk("arst_no_done", n_done - d0, 0);

        // Simultaneous push and pop at occupancy 5.
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        write_burst(bq);
        chk("pp_pre_count", fifo_count, 5);
        k = 0;
        while (!tx_done_tick && (k < 2 * FRAME)) begin
            @(negedge clk);
            k++;
        end
        chk("pp_done_seen", tx_done_tick, 1'b1);
        wr.wr_valid = 1'b1; wr.wr_data = 8'h99;
        @(negedge clk);
        wr.wr_valid = 1'b0;
        chk("pp_count", fifo_count, 5);
        chk("pp_restart", tx, 1'b0);
        drain(10 * FRAME);

`ifdef UART_TX_PARITY_EN
        bq = '{8'h07};
        write_burst(bq);
        @(negedge clk);
        capture(FRAME);
        chk("par07_bit", tx_log[9 * BITCLK + 32], 1'b1);
        chk("par07_done", done_log[703], 1'b1);
        wait_cycles(4);
        bq = '{8'h03};
        write_burst(bq);
        @(negedge clk);
        capture(FRAME);
        chk("par03_bit", tx_log[9 * BITCLK + 32], 1'b0);
        wait_cycles(4);
`endif

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            wr.wr_valid = ($urandom_range(0, 99) < 3);
            wr.wr_data  = 8'($urandom);
            @(negedge clk);
        end
        wr.wr_valid = 1'b0;
        drain((DEPTH + 2) * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
